// File: rtl/dmx2_4bits_buf.sv
// Registered 1-to-2 demultiplexer with a small FIFO per output channel.
// Each accepted word goes to channel 0 or 1 according to s.
// Each channel has its own valid/ready handshake.

// Single-channel FIFO: pointer/count state with reset, storage without reset.
module dmx2_4bits_buf_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic             push,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    cnt
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             pop;

    assign valid = (cnt != '0);
    assign full  = (cnt == CW'(DEPTH));
    assign pop   = valid & ready;
    assign head  = valid ? mem[rptr] : '0;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// Top: steers the incoming word to the selected channel FIFO.
module dmx2_4bits_buf #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // Acceptance depends only on the selected channel's fullness, never on i_valid.
    assign i_ready = s ? ~full1 : ~full0;
    assign push0   = i_valid & i_ready & ~s;
    assign push1   = i_valid & i_ready & s;

    dmx2_4bits_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo0 (
        .clk     (clk),
        .reset_n (reset_n),
        .wdata   (d),
        .push    (push0),
        .ready   (y0_ready),
        .head    (y0),
        .valid   (y0_valid),
        .full    (full0),
        .cnt     (cnt0)
    );

    dmx2_4bits_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo1 (
        .clk     (clk),
        .reset_n (reset_n),
        .wdata   (d),
        .push    (push1),
        .ready   (y1_ready),
        .head    (y1),
        .valid   (y1_valid),
        .full    (full1),
        .cnt     (cnt1)
    );

endmodule

// File: tb/tb_dmx2_4bits_buf.sv
// Bench for dmx2_4bits_buf: directed stimulus plus a negedge scoreboard monitor.
module tb_dmx2_4bits_buf;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] d;
    logic             s;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] y0;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y1;
    logic             y1_valid;
    logic             y1_ready;
    logic [CW-1:0]    cnt0;
    logic [CW-1:0]    cnt1;

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    dmx2_4bits_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .d        (d),
        .s        (s),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs, let one rising edge pass, return just after it.
    task automatic drive(input logic iv, input logic sel, input logic [WIDTH-1:0] dat,
                         input logic r0, input logic r1);
        i_valid  = iv;
        s        = sel;
        d        = dat;
        y0_ready = r0;
        y1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid  = 1'b0;
        s        = 1'b0;
        d        = '0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: checks outputs against the model, then predicts the next edge.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
            q0.delete();
            q1.delete();
        end else begin
            logic exp_rdy;
            exp_rdy = s ? (m_cnt1 != DEPTH) : (m_cnt0 != DEPTH);
            check("mon_cnt0", 32'(cnt0), 32'(m_cnt0));
            check("mon_cnt1", 32'(cnt1), 32'(m_cnt1));
            check("mon_i_ready", 32'(i_ready), 32'(exp_rdy));
            check("mon_y0_valid", 32'(y0_valid), 32'(m_cnt0 != 0));
            check("mon_y1_valid", 32'(y1_valid), 32'(m_cnt1 != 0));
            if (m_cnt0 != 0) begin
                if (y0_ready) begin
                    check("mon_y0_data", 32'(y0), 32'(q0[0]));
                    void'(q0.pop_front());
                    m_cnt0--;
                end
            end else begin
                check("mon_y0_idle", 32'(y0), 32'h0);
            end
            if (m_cnt1 != 0) begin
                if (y1_ready) begin
                    check("mon_y1_data", 32'(y1), 32'(q1[0]));
                    void'(q1.pop_front());
                    m_cnt1--;
                end
            end else begin
                check("mon_y1_idle", 32'(y1), 32'h0);
            end
            if (i_valid && exp_rdy) begin
                if (s) begin
                    q1.push_back(d);
                    m_cnt1++;
                end else begin
                    q0.push_back(d);
                    m_cnt0++;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        i_valid  = 1'b0;
        s        = 1'b0;
        d        = '0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_cnt0", 32'(cnt0), 32'h0);
        check("reset_i_ready", 32'(i_ready), 32'h1);
        check("reset_y0_valid", 32'(y0_valid), 32'h0);

        // Single route to each channel.
        drive(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
        idle();
        check("route_y0", 32'(y0), 32'hA);
        check("route_y0_valid", 32'(y0_valid), 32'h1);
        check("route_y1", 32'(y1), 32'h5);
        check("route_cnt0", 32'(cnt0), 32'h1);
        check("route_cnt1", 32'(cnt1), 32'h1);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        idle();
        check("drain_cnt0", 32'(cnt0), 32'h0);
        check("drain_cnt1", 32'(cnt1), 32'h0);

        // Fill channel 0 and observe backpressure, then pop in order.
        drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        i_valid = 1'b1;
        s       = 1'b0;
        d       = 4'h3;
        #1;
        check("full_cnt0", 32'(cnt0), 32'h2);
        check("full_i_ready_s0", 32'(i_ready), 32'h0);
        s = 1'b1;
        #1;
        check("full_i_ready_s1", 32'(i_ready), 32'h1);
        idle();
        check("pop_first", 32'(y0), 32'h1);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("pop_second", 32'(y0), 32'h2);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        idle();
        check("pop_empty_cnt0", 32'(cnt0), 32'h0);

        // Asynchronous reset mid-cycle with channel 0 full.
        drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        idle();
        check("prereset_cnt0", 32'(cnt0), 32'h2);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_cnt0", 32'(cnt0), 32'h0);
        check("async_cnt1", 32'(cnt1), 32'h0);
        check("async_y0_valid", 32'(y0_valid), 32'h0);
        check("async_y1_valid", 32'(y1_valid), 32'h0);
        check("async_y0", 32'(y0), 32'h0);
        check("async_y1", 32'(y1), 32'h0);
        check("async_i_ready", 32'(i_ready), 32'h1);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Full channel 1 with pop pending: no pass-through on that edge.
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
        i_valid  = 1'b1;
        s        = 1'b1;
        d        = 4'h7;
        y1_ready = 1'b1;
        #1;
        check("fullpop_i_ready", 32'(i_ready), 32'h0);
        @(posedge clk);
        #1;
        check("fullpop_cnt1", 32'(cnt1), 32'h1);
        check("fullpop_y1", 32'(y1), 32'h4);
        @(posedge clk);
        #1;
        check("pushpop_cnt1", 32'(cnt1), 32'h1);
        check("pushpop_y1", 32'(y1), 32'h7);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        idle();
        check("fullpop_drain", 32'(cnt1), 32'h0);

        // Streaming with pointer wrap-around on channel 0.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
            check("stream_cnt0", 32'(cnt0), 32'h1);
            check("stream_y0", 32'(y0), 32'(i));
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        idle();
        check("stream_end_cnt0", 32'(cnt0), 32'h0);

        // Push channel 0 while popping channel 1 on the same edge.
        drive(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'hC, 1'b0, 1'b1);
        idle();
        check("cross_cnt0", 32'(cnt0), 32'h1);
        check("cross_cnt1", 32'(cnt1), 32'h0);
        check("cross_y0", 32'(y0), 32'hC);
        check("cross_y1_valid", 32'(y1_valid), 32'h0);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        idle();
        @(posedge clk);
        #1;

        check("sb_q0_empty", 32'(q0.size()), 32'h0);
        check("sb_q1_empty", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
